// File: rtl/axi_spy_tracer.sv
// Passive AXI monitor. It timestamps completed AR/AW/R/W handshakes into four
// independent first-word-fall-through FIFOs that are read back through one shared port.
module axi_spy_tracer #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 16,
    parameter int WRAP_MODE  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [7:0]            ARLEN,

    input  logic                  AWVALID,
    input  logic                  AWREADY,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [ID_WIDTH-1:0]   AWID,
    input  logic [7:0]            AWLEN,

    input  logic                  RVALID,
    input  logic                  RREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [ID_WIDTH-1:0]   RID,
    input  logic                  RLAST,

    input  logic                  WVALID,
    input  logic                  WREADY,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic                  WLAST,

    input  logic                  spy_en,
    input  logic                  clear,
    input  logic [1:0]            rd_sel,
    input  logic                  rd_en,

    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_payload,
    output logic [ID_WIDTH-1:0]   rd_id,
    output logic [7:0]            rd_aux,
    output logic [TS_WIDTH-1:0]   rd_ts,
    output logic [3:0]            spy_full,
    output logic [3:0]            spy_empty,
    output logic [31:0]           drop_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]       DROP_MAX = 8'hFF;

    logic [TS_WIDTH-1:0] ts;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
        end
    end

    logic [3:0] hs;
    logic [3:0] cap;

    assign hs  = {WVALID && WREADY, RVALID && RREADY, AWVALID && AWREADY, ARVALID && ARREADY};
    assign cap = (spy_en && !clear) ? hs : 4'b0000;

    // Capture record per channel code: 0=AR, 1=AW, 2=R, 3=W.
    logic [DATA_WIDTH-1:0] in_payload [4];
    logic [ID_WIDTH-1:0]   in_id      [4];
    logic [7:0]            in_aux     [4];

    always_comb begin
        in_payload[0] = DATA_WIDTH'(ARADDR);
        in_id[0]      = ARID;
        in_aux[0]     = ARLEN;
        in_payload[1] = DATA_WIDTH'(AWADDR);
        in_id[1]      = AWID;
        in_aux[1]     = AWLEN;
        in_payload[2] = RDATA;
        in_id[2]      = RID;
        in_aux[2]     = {7'b0, RLAST};
        in_payload[3] = WDATA;
        in_id[3]      = '0;
        in_aux[3]     = {7'b0, WLAST};
    end

    logic [DATA_WIDTH-1:0] head_payload [4];
    logic [ID_WIDTH-1:0]   head_id      [4];
    logic [7:0]            head_aux     [4];
    logic [TS_WIDTH-1:0]   head_ts      [4];

    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem_payload [FIFO_DEPTH];
        logic [ID_WIDTH-1:0]   mem_id      [FIFO_DEPTH];
        logic [7:0]            mem_aux     [FIFO_DEPTH];
        logic [TS_WIDTH-1:0]   mem_ts      [FIFO_DEPTH];
        logic [PTR_W-1:0]      wr_ptr;
        logic [PTR_W-1:0]      rd_ptr;
        logic [CNT_W-1:0]      occ;
        logic [7:0]            drops;
        logic                  full;
        logic                  pop;
        logic                  overflow;
        logic                  wr_en;
        logic                  rd_adv;

        assign full     = (occ == FULL_CNT);
        assign pop      = rd_en && (rd_sel == 2'(k)) && (occ != '0) && !clear;
        assign overflow = cap[k] && full && !pop;
        // In overwrite mode a full FIFO has wr_ptr == rd_ptr, so the write lands
        // on the oldest slot and the read pointer steps past it.
        assign wr_en    = cap[k] && (!overflow || (WRAP_MODE != 0));
        assign rd_adv   = pop || (overflow && (WRAP_MODE != 0));

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem_payload[wr_ptr] <= in_payload[k];
                mem_id[wr_ptr]      <= in_id[k];
                mem_aux[wr_ptr]     <= in_aux[k];
                mem_ts[wr_ptr]      <= ts;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n || clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                occ    <= '0;
                drops  <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_adv) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (cap[k] && !pop && !full) begin
                    occ <= occ + 1'b1;
                end else if (pop && !cap[k]) begin
                    occ <= occ - 1'b1;
                end
                if (overflow && (drops != DROP_MAX)) begin
                    drops <= drops + 1'b1;
                end
            end
        end

        assign head_payload[k]    = (occ != '0) ? mem_payload[rd_ptr] : '0;
        assign head_id[k]         = (occ != '0) ? mem_id[rd_ptr]      : '0;
        assign head_aux[k]        = (occ != '0) ? mem_aux[rd_ptr]     : '0;
        assign head_ts[k]         = (occ != '0) ? mem_ts[rd_ptr]      : '0;
        assign spy_full[k]        = full;
        assign spy_empty[k]       = (occ == '0);
        assign drop_cnt[8*k +: 8] = drops;
    end

    always_comb begin
        rd_valid   = !spy_empty[rd_sel];
        rd_payload = head_payload[rd_sel];
        rd_id      = head_id[rd_sel];
        rd_aux     = head_aux[rd_sel];
        rd_ts      = head_ts[rd_sel];
    end

endmodule

// File: tb/tb_axi_spy_tracer.sv
// Directed bench for axi_spy_tracer; a drop-mode and an overwrite-mode instance share stimulus.
module tb_axi_spy_tracer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ARVALID, ARREADY, AWVALID, AWREADY, RVALID, RREADY, WVALID, WREADY;
    logic [31:0] ARADDR, AWADDR;
    logic [3:0]  ARID, AWID, RID;
    logic [7:0]  ARLEN, AWLEN;
    logic        RLAST, WLAST;
    logic [63:0] RDATA, WDATA;
    logic        spy_en, clear, rd_en;
    logic [1:0]  rd_sel;

    logic        rd_valid0, rd_valid1;
    logic [63:0] rd_payload0, rd_payload1;
    logic [3:0]  rd_id0, rd_id1;
    logic [7:0]  rd_aux0, rd_aux1;
    logic [15:0] rd_ts0, rd_ts1;
    logic [3:0]  spy_full0, spy_full1, spy_empty0, spy_empty1;
    logic [31:0] drop_cnt0, drop_cnt1;

    logic [15:0] tb_ts;
    int          checks = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    always @(posedge clk) tb_ts <= (!rst_n || clear) ? 16'd0 : tb_ts + 16'd1;

    axi_spy_tracer #(.WRAP_MODE(0)) u_drop (
        .clk(clk), .rst_n(rst_n),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RID(RID), .RLAST(RLAST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
        .spy_en(spy_en), .clear(clear), .rd_sel(rd_sel), .rd_en(rd_en),
        .rd_valid(rd_valid0), .rd_payload(rd_payload0), .rd_id(rd_id0), .rd_aux(rd_aux0),
        .rd_ts(rd_ts0), .spy_full(spy_full0), .spy_empty(spy_empty0), .drop_cnt(drop_cnt0)
    );

    axi_spy_tracer #(.WRAP_MODE(1)) u_wrap (
        .clk(clk), .rst_n(rst_n),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RID(RID), .RLAST(RLAST),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
        .spy_en(spy_en), .clear(clear), .rd_sel(rd_sel), .rd_en(rd_en),
        .rd_valid(rd_valid1), .rd_payload(rd_payload1), .rd_id(rd_id1), .rd_aux(rd_aux1),
        .rd_ts(rd_ts1), .spy_full(spy_full1), .spy_empty(spy_empty1), .drop_cnt(drop_cnt1)
    );

    typedef struct {
        logic [1:0]  ch;
        logic        vld;
        logic        rdy;
        logic        en;
        logic [63:0] data;
        logic [3:0]  id;
        logic [7:0]  aux;
        logic        exp_cap;
        logic [63:0] exp_payload;
        logic [3:0]  exp_id;
        logic [7:0]  exp_aux;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [1:0] ch);
        rd_sel = ch;
        #1;
    endtask

    task automatic idle_axi();
        ARVALID = 0; ARREADY = 0; ARADDR = '0; ARID = '0; ARLEN = '0;
        AWVALID = 0; AWREADY = 0; AWADDR = '0; AWID = '0; AWLEN = '0;
        RVALID = 0; RREADY = 0; RDATA = '0; RID = '0; RLAST = 0;
        WVALID = 0; WREADY = 0; WDATA = '0; WLAST = 0;
    endtask

    task automatic drive_vec(input vec_t v);
        idle_axi();
        spy_en = v.en;
        case (v.ch)
            2'd0: begin ARVALID = v.vld; ARREADY = v.rdy; ARADDR = v.data[31:0]; ARID = v.id; ARLEN = v.aux; end
            2'd1: begin AWVALID = v.vld; AWREADY = v.rdy; AWADDR = v.data[31:0]; AWID = v.id; AWLEN = v.aux; end
            2'd2: begin RVALID = v.vld; RREADY = v.rdy; RDATA = v.data; RID = v.id; RLAST = v.aux[0]; end
            default: begin WVALID = v.vld; WREADY = v.rdy; WDATA = v.data; WLAST = v.aux[0]; end
        endcase
    endtask

    task automatic do_clear();
        clear = 1;
        step();
        clear = 0;
    endtask

    initial begin
        logic [15:0] snap;
        logic [63:0] e_pay [4];
        logic [3:0]  e_id  [4];
        logic [7:0]  e_aux [4];

        //         ch    vld   rdy   en    data                    id    aux    cap   payload                 id    aux
        vecs[0] = '{2'd0, 1'b1, 1'b1, 1'b1, 64'h1234,               4'h5, 8'h03, 1'b1, 64'h1234,               4'h5, 8'h03};
        vecs[1] = '{2'd0, 1'b1, 1'b0, 1'b1, 64'h5678,               4'h6, 8'h04, 1'b0, 64'h0,                  4'h0, 8'h00};
        vecs[2] = '{2'd1, 1'b1, 1'b1, 1'b1, 64'hDEADBEEF,           4'hA, 8'hFF, 1'b1, 64'hDEADBEEF,           4'hA, 8'hFF};
        vecs[3] = '{2'd2, 1'b1, 1'b1, 1'b1, 64'h0123456789ABCDEF,   4'h7, 8'h01, 1'b1, 64'h0123456789ABCDEF,   4'h7, 8'h01};
        vecs[4] = '{2'd2, 1'b0, 1'b1, 1'b1, 64'h99,                 4'h2, 8'h01, 1'b0, 64'h0,                  4'h0, 8'h00};
        vecs[5] = '{2'd3, 1'b1, 1'b1, 1'b1, 64'hFFFF000011112222,   4'h9, 8'h00, 1'b1, 64'hFFFF000011112222,   4'h0, 8'h00};
        vecs[6] = '{2'd3, 1'b1, 1'b1, 1'b0, 64'hABCD,               4'h1, 8'h01, 1'b0, 64'h0,                  4'h0, 8'h00};
        vecs[7] = '{2'd0, 1'b1, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF,   4'hF, 8'h00, 1'b1, 64'h00000000FFFFFFFF,   4'hF, 8'h00};
        vecs[8] = '{2'd3, 1'b1, 1'b1, 1'b1, 64'h5,                  4'h3, 8'h01, 1'b1, 64'h5,                  4'h0, 8'h01};

        // Reset state, with a handshake present that must not be captured
        rst_n = 0; spy_en = 1; clear = 0; rd_en = 0; rd_sel = 0;
        idle_axi();
        ARVALID = 1; ARREADY = 1; ARADDR = 32'h44;
        step(); step();
        idle_axi();
        look(0);
        chk("rst_empty", spy_empty0, 4'hF);
        chk("rst_full", spy_full0, 4'h0);
        chk("rst_rd_valid", rd_valid0, 1'b0);
        chk("rst_payload", rd_payload0, 64'h0);
        chk("rst_ts", rd_ts0, 16'h0);
        chk("rst_drop", drop_cnt0, 32'h0);
        chk("rst_empty_wrap", spy_empty1, 4'hF);
        rst_n = 1;
        step();

        // Single AR capture at ts=5
        do_clear();
        repeat (5) step();
        ARVALID = 1; ARREADY = 1; ARADDR = 32'h1000; ARID = 4'd3; ARLEN = 8'd7;
        step();
        idle_axi();
        look(0);
        chk("ar_valid", rd_valid0, 1'b1);
        chk("ar_payload", rd_payload0, 64'h1000);
        chk("ar_id", rd_id0, 4'd3);
        chk("ar_aux", rd_aux0, 8'd7);
        chk("ar_ts", rd_ts0, 16'd5);
        rd_en = 1; step(); rd_en = 0;
        chk("ar_pop_empty", spy_empty0, 4'hF);

        // Table of single-channel vectors
        for (int i = 0; i < 9; i++) begin
            drive_vec(vecs[i]);
            snap = tb_ts;
            step();
            idle_axi();
            spy_en = 1;
            look(vecs[i].ch);
            chk($sformatf("vec%0d_valid", i), rd_valid0, vecs[i].exp_cap);
            if (vecs[i].exp_cap) begin
                chk($sformatf("vec%0d_payload", i), rd_payload0, vecs[i].exp_payload);
                chk($sformatf("vec%0d_id", i), rd_id0, vecs[i].exp_id);
                chk($sformatf("vec%0d_aux", i), rd_aux0, vecs[i].exp_aux);
                chk($sformatf("vec%0d_ts", i), rd_ts0, snap);
                rd_en = 1; step(); rd_en = 0;
            end else begin
                chk($sformatf("vec%0d_zero", i), rd_payload0, 64'h0);
            end
            chk($sformatf("vec%0d_empty", i), spy_empty0, 4'hF);
        end

        // All four channels in one cycle
        ARVALID = 1; ARREADY = 1; ARADDR = 32'h11; ARID = 4'd1; ARLEN = 8'd1;
        AWVALID = 1; AWREADY = 1; AWADDR = 32'h22; AWID = 4'd2; AWLEN = 8'd2;
        RVALID = 1; RREADY = 1; RDATA = 64'h33; RID = 4'd3; RLAST = 1;
        WVALID = 1; WREADY = 1; WDATA = 64'h44; WLAST = 1;
        step();
        idle_axi();
        chk("all4_empty", spy_empty0, 4'h0);
        e_pay = '{64'h11, 64'h22, 64'h33, 64'h44};
        e_id  = '{4'd1, 4'd2, 4'd3, 4'd0};
        e_aux = '{8'd1, 8'd2, 8'd1, 8'd1};
        for (int c = 0; c < 4; c++) begin
            look(2'(c));
            chk($sformatf("all4_payload%0d", c), rd_payload0, e_pay[c]);
            chk($sformatf("all4_id%0d", c), rd_id0, e_id[c]);
            chk($sformatf("all4_aux%0d", c), rd_aux0, e_aux[c]);
        end
        for (int c = 0; c < 4; c++) begin
            rd_sel = 2'(c); rd_en = 1; step();
        end
        rd_en = 0;
        chk("all4_drained", spy_empty0, 4'hF);

        // Nine W beats into an eight-deep FIFO, no pops
        for (int i = 1; i <= 9; i++) begin
            WVALID = 1; WREADY = 1; WDATA = 64'(i); WLAST = 0;
            step();
        end
        idle_axi();
        chk("w9_full_drop", spy_full0[3], 1'b1);
        chk("w9_drop_drop", drop_cnt0[31:24], 8'd1);
        chk("w9_full_wrap", spy_full1[3], 1'b1);
        chk("w9_drop_wrap", drop_cnt1[31:24], 8'd1);
        for (int j = 0; j < 8; j++) begin
            look(3);
            chk($sformatf("w9_pop%0d_drop", j), rd_payload0, 64'(j + 1));
            chk($sformatf("w9_pop%0d_wrap", j), rd_payload1, 64'(j + 2));
            rd_en = 1; step(); rd_en = 0;
        end
        chk("w9_empty_drop", spy_empty0[3], 1'b1);
        chk("w9_empty_wrap", spy_empty1[3], 1'b1);

        // AW full, capture and pop in the same cycle
        do_clear();
        for (int i = 0; i < 8; i++) begin
            AWVALID = 1; AWREADY = 1; AWADDR = 32'h200 + 32'(i);
            step();
        end
        idle_axi();
        chk("aw_full", spy_full0[1], 1'b1);
        AWVALID = 1; AWREADY = 1; AWADDR = 32'h2FF;
        rd_sel = 1; rd_en = 1;
        #1;
        chk("aw_head_before", rd_payload0, 64'h200);
        step();
        idle_axi();
        rd_en = 0;
        look(1);
        chk("aw_still_full", spy_full0[1], 1'b1);
        chk("aw_no_drop", drop_cnt0[15:8], 8'd0);
        chk("aw_no_drop_wrap", drop_cnt1[15:8], 8'd0);
        chk("aw_head_after", rd_payload0, 64'h201);
        for (int j = 0; j < 7; j++) begin
            rd_en = 1; step();
        end
        rd_en = 0;
        #1;
        chk("aw_tail", rd_payload0, 64'h2FF);
        rd_en = 1; step(); step(); step();
        rd_en = 0;
        chk("aw_empty_pop_ignored", spy_empty0[1], 1'b1);
        chk("aw_empty_not_full", spy_full0[1], 1'b0);
        AWVALID = 1; AWREADY = 1; AWADDR = 32'h55;
        step();
        idle_axi();
        look(1);
        chk("aw_after_empty_pop", rd_payload0, 64'h55);
        chk("aw_after_empty_single", spy_full0[1], 1'b0);

        // AR drop counter saturation, then clear against concurrent capture and pop
        do_clear();
        for (int i = 0; i < 300; i++) begin
            ARVALID = 1; ARREADY = 1; ARADDR = 32'(i);
            step();
        end
        idle_axi();
        chk("sat_drop", drop_cnt0, 32'h0000_00FF);
        chk("sat_drop_wrap", drop_cnt1, 32'h0000_00FF);
        chk("sat_full", spy_full0[0], 1'b1);
        clear = 1; rd_sel = 0; rd_en = 1;
        ARVALID = 1; ARREADY = 1; ARADDR = 32'h66;
        step();
        clear = 0; rd_en = 0;
        idle_axi();
        chk("clr_empty", spy_empty0, 4'hF);
        chk("clr_drop", drop_cnt0, 32'h0);
        chk("clr_full", spy_full0, 4'h0);
        ARVALID = 1; ARREADY = 1; ARADDR = 32'h77;
        step();
        idle_axi();
        look(0);
        chk("clr_ts", rd_ts0, 16'd0);
        chk("clr_payload", rd_payload0, 64'h77);

        // Reset mid-operation overrides capture and pop
        WVALID = 1; WREADY = 1; WDATA = 64'h88;
        step();
        rst_n = 0; rd_en = 1;
        ARVALID = 1; ARREADY = 1; ARADDR = 32'h99;
        step();
        rst_n = 1; rd_en = 0;
        idle_axi();
        look(0);
        chk("midrst_empty", spy_empty0, 4'hF);
        chk("midrst_valid", rd_valid0, 1'b0);
        chk("midrst_payload", rd_payload0, 64'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
